// File: rtl/matrix_stream_feeder.sv
// rtl/matrix_stream_feeder.sv - streams 4x4 A/B operands to a multiplier and buffers its four result words.
// Optional result-wait timeout: define FEEDER_TIMEOUT_EN.
module matrix_stream_feeder #(
  parameter int WIDTH          = 8,
  parameter int NUM_ELEMENTS   = 4,
  parameter int MATRIX_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ld_valid,
  input  logic                          ld_sel,
  input  logic [3:0]                    ld_addr,
  input  logic [WIDTH-1:0]              ld_data,
  input  logic                          start,
  output logic [NUM_ELEMENTS*WIDTH-1:0] rdata,
  output logic                          read_en,
  output logic                          write_en,
  input  logic [NUM_ELEMENTS*WIDTH-1:0] Res,
  input  logic                          write_ready,
  input  logic [1:0]                    res_addr,
  output logic [NUM_ELEMENTS*WIDTH-1:0] res_data,
  output logic                          busy,
`ifdef FEEDER_TIMEOUT_EN
  output logic                          done,
  output logic                          timeout
`else
  output logic                          done
`endif
);

  localparam int NCELL = MATRIX_WIDTH * MATRIX_WIDTH;
  localparam int DW    = NUM_ELEMENTS * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_beat;
  logic [1:0]       r_cap_cnt;
  logic [DW-1:0]    r_rdata;
  logic             r_read_en;
  logic             r_write_en;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_a [NCELL];
  logic [WIDTH-1:0] r_b [NCELL];
  logic [DW-1:0]    r_res [4];

  logic [WIDTH-1:0] w_a_nxt [NCELL];
  logic [WIDTH-1:0] w_b_nxt [NCELL];
  logic [2:0]       w_nb;
  logic [3:0]       w_idx_hi;
  logic [3:0]       w_idx_lo;
  logic [DW-1:0]    w_beat_word;

`ifdef FEEDER_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0] TO_LAST = WCW'(TIMEOUT_CYCLES - 1);
  logic [WCW-1:0] r_wait_cnt;
  logic           r_timeout;
  assign timeout = r_timeout;
`endif

  // Host writes are folded in before the operand mux so a load coinciding
  // with start is already visible in beat 0.
  always_comb begin
    w_a_nxt = r_a;
    w_b_nxt = r_b;
    if (r_state == S_IDLE && ld_valid) begin
      if (ld_sel) w_b_nxt[ld_addr] = ld_data;
      else        w_a_nxt[ld_addr] = ld_data;
    end
  end

  // Beat n: col = n>>1, row = 2*(n&1); index = row*4 + col.
  assign w_nb        = (r_state == S_IDLE) ? 3'd0 : r_beat + 3'd1;
  assign w_idx_hi    = {w_nb[0], 1'b0, w_nb[2:1]};
  assign w_idx_lo    = {w_nb[0], 1'b1, w_nb[2:1]};
  assign w_beat_word = {w_a_nxt[w_idx_hi], w_a_nxt[w_idx_lo],
                        w_b_nxt[w_idx_hi], w_b_nxt[w_idx_lo]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_beat     <= 3'd0;
      r_cap_cnt  <= 2'd0;
      r_rdata    <= '0;
      r_read_en  <= 1'b0;
      r_write_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < NCELL; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
      for (int i = 0; i < 4; i++) r_res[i] <= '0;
`ifdef FEEDER_TIMEOUT_EN
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_a <= w_a_nxt;
      r_b <= w_b_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_STREAM;
            r_beat    <= 3'd0;
            r_rdata   <= w_beat_word;
            r_read_en <= 1'b1;
            r_busy    <= 1'b1;
            r_cap_cnt <= 2'd0;
`ifdef FEEDER_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
          end
        end
        S_STREAM: begin
          if (r_beat == 3'd7) begin
            r_state    <= S_WAIT;
            r_read_en  <= 1'b0;
            r_rdata    <= '0;
            r_write_en <= 1'b1;
`ifdef FEEDER_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end else begin
            r_beat  <= w_nb;
            r_rdata <= w_beat_word;
          end
        end
        S_WAIT: begin
          if (write_ready) begin
            r_res[r_cap_cnt] <= Res;
            r_cap_cnt        <= r_cap_cnt + 2'd1;
`ifdef FEEDER_TIMEOUT_EN
            r_wait_cnt       <= '0;
`endif
            if (r_cap_cnt == 2'd3) begin
              r_state    <= S_DONE;
              r_write_en <= 1'b0;
              r_done     <= 1'b1;
            end
          end
`ifdef FEEDER_TIMEOUT_EN
          else if (r_wait_cnt == TO_LAST) begin
            r_state    <= S_DONE;
            r_write_en <= 1'b0;
            r_done     <= 1'b1;
            r_timeout  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdata    = r_rdata;
  assign read_en  = r_read_en;
  assign write_en = r_write_en;
  assign busy     = r_busy;
  assign done     = r_done;
  assign res_data = r_res[res_addr];

endmodule

// File: tb/tb_matrix_stream_feeder.sv
// tb/tb_matrix_stream_feeder.sv - randomized self-checking bench for matrix_stream_feeder.
module tb_matrix_stream_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, ld_sel, start, write_ready;
  logic [3:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [31:0] rdata, Res, res_data;
  logic        read_en, write_en, busy, done;
  logic [1:0]  res_addr;
`ifdef FEEDER_TIMEOUT_EN
  logic        timeout;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  ma [16];
  logic [7:0]  mb [16];
  logic [31:0] mres [4];

  always #5 clk = ~clk;

  matrix_stream_feeder dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .rdata(rdata),
    .read_en(read_en), .write_en(write_en), .Res(Res), .write_ready(write_ready),
    .res_addr(res_addr), .res_data(res_data), .busy(busy),
`ifdef FEEDER_TIMEOUT_EN
    .timeout(timeout),
`endif
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_beat(input int n);
    int col, row;
    col = n / 2;
    row = 2 * (n % 2);
    return {ma[row*4+col], ma[(row+1)*4+col], mb[row*4+col], mb[(row+1)*4+col]};
  endfunction

  task automatic load(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    if (sel) mb[addr] = data; else ma[addr] = data;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic chk_results();
    for (int a = 0; a < 4; a++) begin
      res_addr = a[1:0];
      #1;
      chk($sformatf("res_data[%0d]", a), res_data, mres[a]);
    end
  endtask

  // Caller may leave ld_valid set so its write coincides with start.
  task automatic do_stream(input logic noise);
    start = 1'b1;
    tick();
    start = 1'b0; ld_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("read_en b%0d", n), {31'd0, read_en}, 32'd1);
      chk($sformatf("rdata b%0d", n), rdata, exp_beat(n));
      chk($sformatf("flags b%0d", n), {29'd0, busy, write_en, done}, 32'b100);
      if (noise && (n == 2 || n == 5)) begin
        ld_valid = 1'b1; ld_sel = 1'($urandom); ld_addr = 4'($urandom);
        ld_data = 8'hFF; start = 1'b1;
      end
      tick();
      ld_valid = 1'b0; start = 1'b0;
    end
    chk("post read_en", {31'd0, read_en}, 32'd0);
    chk("post rdata", rdata, 32'd0);
    chk("wait write_en", {31'd0, write_en}, 32'd1);
  endtask

  task automatic do_capture(input logic random_mode);
    logic [5:0] pat;
    logic       wr;
    int         caps;
    pat  = 6'b110101;
    caps = 0;
    for (int c = 0; c < 64 && caps < 4; c++) begin
      if (random_mode) wr = (c >= 32) ? 1'b1 : 1'($urandom);
      else             wr = (c < 6) ? pat[c] : 1'b1;
      write_ready = wr;
      Res = $urandom;
      tick();
      if (wr) begin
        mres[caps] = Res;
        caps++;
      end
      write_ready = 1'b0;
      if (caps == 4)
        chk("done pulse", {29'd0, done, busy, write_en}, 32'b110);
      else
        chk("waiting", {29'd0, done, busy, write_en}, 32'b011);
    end
    chk("capture count", caps, 4);
    tick();
    chk("after done", {30'd0, done, busy}, 32'd0);
    chk_results();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; write_ready = 1'b0; Res = '0; res_addr = '0;
    for (int i = 0; i < 16; i++) begin ma[i] = '0; mb[i] = '0; end
    for (int i = 0; i < 4; i++) mres[i] = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset outs", {28'd0, read_en, write_en, busy, done}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk_results();

    // Directed load; final write coincides with start.
    for (int i = 0; i < 16; i++) load(1'b0, 4'(i), 8'(i + 1));
    for (int i = 0; i < 15; i++) load(1'b1, 4'(i), 8'(8'h10 + i));
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 4'd15; ld_data = 8'h1F; mb[15] = 8'h1F;
    start = 1'b1;
    tick();
    start = 1'b0; ld_valid = 1'b0;
    chk("beat0 const", rdata, 32'h01051014);
    tick();
    chk("beat1 const", rdata, 32'h090D181C);
    tick();
    chk("beat2 const", rdata, 32'h02061115);
    for (int n = 3; n < 8; n++) tick();
    chk("beat7 model", rdata, exp_beat(7));
    tick();
    chk("beat7 last", {30'd0, read_en, write_en}, 32'b01);
    for (int i = 0; i < 4; i++) begin
      write_ready = 1'b1; Res = 32'hAABBCC00 + i; mres[i] = Res;
      tick();
    end
    write_ready = 1'b0;
    chk("directed done", {30'd0, done, busy}, 32'b11);
    tick();
    chk("directed idle", {30'd0, done, busy}, 32'b00);
    chk_results();

    // Toggled write_ready pattern with noise during the stream.
    do_stream(1'b1);
    do_capture(1'b0);

    // Randomized transactions.
    for (int t = 0; t < 8; t++) begin
      int nl;
      nl = $urandom_range(0, 6);
      for (int k = 0; k < nl; k++) load(1'($urandom), 4'($urandom), 8'($urandom));
      write_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin Res = $urandom; tick(); end
      write_ready = 1'b0;
      chk_results();
      if ($urandom_range(0, 1) == 1) begin
        ld_valid = 1'b1; ld_sel = 1'($urandom); ld_addr = 4'($urandom); ld_data = 8'($urandom);
        if (ld_sel) mb[ld_addr] = ld_data; else ma[ld_addr] = ld_data;
      end
      do_stream(t[0]);
      do_capture(1'b1);
    end

    // Reset in the middle of beat 3 aborts the transaction.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre-abort beat3", rdata, exp_beat(3));
    #2 reset = 1'b0;
    #1;
    chk("abort outs", {28'd0, read_en, write_en, busy, done}, 32'd0);
    chk("abort rdata", rdata, 32'd0);
    for (int i = 0; i < 16; i++) begin ma[i] = '0; mb[i] = '0; end
    for (int i = 0; i < 4; i++) mres[i] = '0;
    chk_results();
    @(posedge clk);
    #2 reset = 1'b1;
    do_stream(1'b0);
    do_capture(1'b1);

`ifdef FEEDER_TIMEOUT_EN
    begin
      int cyc;
      do_stream(1'b0);
      cyc = 0;
      while (!done && cyc < 1100) begin tick(); cyc++; end
      chk("timeout cycles", cyc, 1024);
      chk("timeout flag", {31'd0, timeout}, 32'd1);
      tick();
      chk("timeout sticky", {31'd0, timeout}, 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("timeout cleared", {31'd0, timeout}, 32'd0);
      for (int n = 0; n < 7; n++) tick();
      tick();
      do_capture(1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
